fifo_ptr_ctrl: RTL and testbench

- Parametrised read/write pointer controller for a single-clock FIFO built around an external simple dual-port RAM with synchronous read.
- Owns both pointers, the occupancy count, and the full/empty/almost flags.
- Supports standard and first-word-fall-through (FWFT) read modes.
- Sits between the FIFO top level and the RAM. Replaces the separate standalone read/write address counters.

---
 rtl/fifo_ptr_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer, occupancy and flag controller for a single-clock FIFO around a sync-read dual-port RAM.
// Optional sticky overflow/underflow outputs are compiled in when FIFO_ERR_FLAGS_EN is defined.
module fifo_ptr_ctrl #(
    parameter int K         = 4,
    parameter int FWFT      = 1,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic         wr_accept,
    output logic         rd_accept,
    output logic [K-1:0] wr_addr,
    output logic [K-1:0] rd_addr,
    output logic [K:0]   count,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic         overflow,
    output logic         underflow
`endif
);

    localparam logic [K:0] ZERO  = '0;
    localparam logic [K:0] ONE   = {{K{1'b0}}, 1'b1};
    localparam logic [K:0] DEPTH = {1'b1, {K{1'b0}}};
    localparam logic [K:0] AF_TH = AFULL_TH[K:0];
    localparam logic [K:0] AE_TH = AEMPTY_TH[K:0];

    logic [K:0] wr_ptr;
    logic [K:0] rd_ptr;
    logic [K:0] wr_ptr_next;
    logic [K:0] rd_ptr_next;
    logic [K:0] count_next;
    logic       empty_next;

    assign wr_accept   = wr_en & ~full;
    assign rd_accept   = rd_en & ~empty;
    assign wr_ptr_next = wr_ptr + {{K{1'b0}}, wr_accept};
    assign rd_ptr_next = rd_ptr + {{K{1'b0}}, rd_accept};
    assign wr_addr     = wr_ptr[K-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Look one word ahead on a pop so the RAM output always holds the head entry.
            assign rd_addr = rd_ptr_next[K-1:0];
            // Hold empty for one extra edge after the first write to cover the RAM read latency.
            assign empty_next = (count_next == ZERO) | (count == ZERO);
        end else begin : g_std
            assign rd_addr    = rd_ptr[K-1:0];
            assign empty_next = (count_next == ZERO);
        end
    endgenerate

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr       <= ZERO;
            rd_ptr       <= ZERO;
            count        <= ZERO;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            full         <= (count_next == DEPTH);
            empty        <= empty_next;
            almost_full  <= (count_next >= AF_TH);
            almost_empty <= (count_next <= AE_TH);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)  overflow  <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: one standard-mode and one FWFT instance checked against a scoreboard model.
// Covers the sticky error flags when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_ptr_ctrl;

    localparam int K     = 4;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic wr0, rd0, wr1, rd1;
    logic wa0, ra0, wa1, ra1;
    logic [K-1:0] waddr0, raddr0, waddr1, raddr1;
    logic [K:0]   cnt0, cnt1;
    logic full0, empty0, af0, ae0;
    logic full1, empty1, af1, ae1;
`ifdef FIFO_ERR_FLAGS_EN
    logic ovf0, udf0, ovf1, udf1;
`endif

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.K(K), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr0), .rd_en(rd0),
        .wr_accept(wa0), .rd_accept(ra0), .wr_addr(waddr0), .rd_addr(raddr0),
        .count(cnt0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ovf0), .underflow(udf0)
`endif
    );

    fifo_ptr_ctrl #(.K(K), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1),
        .wr_accept(wa1), .rd_accept(ra1), .wr_addr(waddr1), .rd_addr(raddr1),
        .count(cnt1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ovf1), .underflow(udf1)
`endif
    );

    typedef struct {
        int count;
        bit full;
        bit empty;
        bit af;
        bit ae;
        int waddr;
        int raddr;
    } exp_t;

    typedef struct {
        logic wr;
        logic rd;
        logic exp_wacc;
        int   exp_count;
        logic exp_full;
        logic exp_af;
        int   exp_waddr;
        int   exp_raddr;
    } vec_t;

    exp_t exp_q[$];
    int   m_cnt[2];
    int   m_wp[2];
    int   m_rp[2];
    bit   m_emp[2];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests, check the combinational strobes, and queue the post-edge expectation.
    task automatic drive(input logic r, input logic w_0, input logic r_0, input logic w_1, input logic r_1);
        bit   wv[2];
        bit   rv[2];
        bit   wa;
        bit   ra;
        int   cn;
        exp_t e;
        wv[0] = w_0; rv[0] = r_0; wv[1] = w_1; rv[1] = r_1;
        @(negedge clk);
        rst = r; wr0 = w_0; rd0 = r_0; wr1 = w_1; rd1 = r_1;
        #1;
        for (int i = 0; i < 2; i++) begin
            wa = wv[i] && (m_cnt[i] != DEPTH);
            ra = rv[i] && !m_emp[i];
            if (!r) begin
                check($sformatf("u%0d wr_accept", i), (i == 0) ? wa0 : wa1, wa);
                check($sformatf("u%0d rd_accept", i), (i == 0) ? ra0 : ra1, ra);
                if (i == 1) check("u1 rd_addr lookahead", raddr1, (m_rp[1] + ra) % DEPTH);
            end
            if (r) begin
                m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0; m_emp[i] = 1'b1;
            end else begin
                cn = m_cnt[i] + int'(wa) - int'(ra);
                m_emp[i] = (i == 0) ? (cn == 0) : (cn == 0 || m_cnt[i] == 0);
                m_cnt[i] = cn;
                m_wp[i] = (m_wp[i] + int'(wa)) % (2 * DEPTH);
                m_rp[i] = (m_rp[i] + int'(ra)) % (2 * DEPTH);
            end
            e.count = m_cnt[i];
            e.full  = (m_cnt[i] == DEPTH);
            e.empty = m_emp[i];
            e.af    = (m_cnt[i] >= AF);
            e.ae    = (m_cnt[i] <= AE);
            e.waddr = m_wp[i] % DEPTH;
            e.raddr = (i == 0) ? m_rp[i] % DEPTH : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: no expectation queued for u%0d", i);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("u%0d count", i), (i == 0) ? 32'(cnt0) : 32'(cnt1), e.count);
                check($sformatf("u%0d full", i), (i == 0) ? full0 : full1, e.full);
                check($sformatf("u%0d empty", i), (i == 0) ? empty0 : empty1, e.empty);
                check($sformatf("u%0d almost_full", i), (i == 0) ? af0 : af1, e.af);
                check($sformatf("u%0d almost_empty", i), (i == 0) ? ae0 : ae1, e.ae);
                check($sformatf("u%0d wr_addr", i), (i == 0) ? 32'(waddr0) : 32'(waddr1), e.waddr);
                if (e.raddr >= 0) check("u0 rd_addr", raddr0, e.raddr);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic w_0, input logic r_0, input logic w_1, input logic r_1);
        drive(r, w_0, r_0, w_1, r_1);
        tick();
    endtask

    initial begin
        vec_t vecs[18];

        for (int i = 0; i < 17; i++) begin
            vecs[i].wr        = 1'b1;
            vecs[i].rd        = 1'b0;
            vecs[i].exp_wacc  = (i < 16);
            vecs[i].exp_count = (i < 16) ? i + 1 : 16;
            vecs[i].exp_full  = (i >= 15);
            vecs[i].exp_af    = (i >= 13);
            vecs[i].exp_waddr = (i < 16) ? (i + 1) % 16 : 0;
            vecs[i].exp_raddr = 0;
        end
        vecs[17].wr        = 1'b1;
        vecs[17].rd        = 1'b1;
        vecs[17].exp_wacc  = 1'b0;
        vecs[17].exp_count = 15;
        vecs[17].exp_full  = 1'b0;
        vecs[17].exp_af    = 1'b1;
        vecs[17].exp_waddr = 0;
        vecs[17].exp_raddr = 1;

        rst = 1'b1; wr0 = 1'b0; rd0 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0; m_emp[i] = 1'b1;
        end

        // Reset then idle
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        check("t1 u0 empty", empty0, 1'b1);
        check("t1 u0 almost_empty", ae0, 1'b1);
        check("t1 u0 full", full0, 1'b0);
        check("t1 u0 count", cnt0, 0);
        check("t1 u0 wr_addr", waddr0, 0);
        check("t1 u0 rd_addr", raddr0, 0);
        check("t1 u1 empty", empty1, 1'b1);
        check("t1 u1 count", cnt1, 0);
        check("t1 u1 rd_addr", raddr1, 0);

        // Standard mode: fill past full, then push+pop while full
        foreach (vecs[i]) begin
            drive(0, vecs[i].wr, vecs[i].rd, 0, 0);
            check($sformatf("t2 vec%0d wr_accept", i), wa0, vecs[i].exp_wacc);
            tick();
            check($sformatf("t2 vec%0d count", i), cnt0, vecs[i].exp_count);
            check($sformatf("t2 vec%0d full", i), full0, vecs[i].exp_full);
            check($sformatf("t2 vec%0d almost_full", i), af0, vecs[i].exp_af);
            check($sformatf("t2 vec%0d wr_addr", i), waddr0, vecs[i].exp_waddr);
            check($sformatf("t2 vec%0d rd_addr", i), raddr0, vecs[i].exp_raddr);
        end

        // Steady push+pop at count 5 across pointer wrap
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 1, 0);
        check("t3 u0 start wr_addr", waddr0, 5);
        check("t3 u0 start rd_addr", raddr0, 0);
        repeat (40) cyc(0, 1, 1, 1, 1);
        check("t3 u0 count", cnt0, 5);
        check("t3 u0 almost_empty", ae0, 1'b0);
        check("t3 u0 wr_addr", waddr0, 13);
        check("t3 u0 rd_addr", raddr0, 8);
        check("t3 u1 count", cnt1, 5);
        check("t3 u1 wr_addr", waddr1, 13);

        // FWFT first-word latency and gap-cycle pop rejection
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("t4 count after write", cnt1, 1);
        check("t4 empty after write", empty1, 1'b1);
        drive(0, 0, 0, 0, 1);
        check("t4 gap pop rejected", ra1, 1'b0);
        tick();
        check("t4 empty after gap", empty1, 1'b0);
        check("t4 count after gap", cnt1, 1);
        drive(0, 0, 0, 0, 1);
        check("t4 pop accepted", ra1, 1'b1);
        check("t4 rd_addr during pop", raddr1, 1);
        tick();
        check("t4 empty after pop", empty1, 1'b1);
        check("t4 count after pop", cnt1, 0);

        // Reset mid-operation with both requests asserted
        cyc(1, 0, 0, 0, 0);
        repeat (9) cyc(0, 1, 0, 1, 0);
        check("t5 u0 count before", cnt0, 9);
        cyc(1, 1, 1, 1, 1);
        check("t5 u0 count", cnt0, 0);
        check("t5 u0 empty", empty0, 1'b1);
        check("t5 u0 wr_addr", waddr0, 0);
        check("t5 u0 rd_addr", raddr0, 0);
        check("t5 u1 count", cnt1, 0);
        check("t5 u1 empty", empty1, 1'b1);
        check("t5 u1 wr_addr", waddr1, 0);
        check("t5 u1 rd_addr", raddr1, 0);
        cyc(0, 0, 0, 0, 0);
        check("t5 u0 count idle", cnt0, 0);

`ifdef FIFO_ERR_FLAGS_EN
        // Sticky error flags
        cyc(1, 0, 0, 0, 0);
        check("t6 u0 underflow reset", udf0, 1'b0);
        check("t6 u0 overflow reset", ovf0, 1'b0);
        cyc(0, 0, 1, 0, 1);
        check("t6 u0 underflow", udf0, 1'b1);
        check("t6 u1 underflow", udf1, 1'b1);
        check("t6 u0 overflow clear", ovf0, 1'b0);
        repeat (16) cyc(0, 1, 0, 1, 0);
        check("t6 u0 underflow sticky", udf0, 1'b1);
        check("t6 u1 underflow sticky", udf1, 1'b1);
        cyc(0, 1, 0, 1, 0);
        check("t6 u0 overflow", ovf0, 1'b1);
        check("t6 u1 overflow", ovf1, 1'b1);
        cyc(1, 0, 0, 0, 0);
        check("t6 u0 overflow cleared", ovf0, 1'b0);
        check("t6 u0 underflow cleared", udf0, 1'b0);
        check("t6 u1 overflow cleared", ovf1, 1'b0);
        check("t6 u1 underflow cleared", udf1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
